// File: rtl/debounce_pkg.sv
// Shared definitions for the switch bounce generator and its LFSR.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BOUNCE = 2'd1,
      SETTLE = 2'd2
   } bounce_state_t;

   localparam int          LFSR_W       = 16;
   // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   function automatic logic [15:0] fix_seed(input logic [15:0] s);
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

   // One Fibonacci step: shift left, feedback enters at bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 16-bit Fibonacci LFSR that supplies the pseudo-random bounce pattern.
module bounce_lfsr
   import debounce_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] out
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   // Advance only when enabled, otherwise hold.
   always_comb begin
      lfsr_d = lfsr_q;
      if (en) begin
         lfsr_d = lfsr_step(lfsr_q);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // LFSR register, reloaded with the (non-zero) seed on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= fix_seed(seed);
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign out = lfsr_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Emulates a bouncing mechanical switch: B pseudo-random cycles ending in a
// guaranteed glitch, then max(S,1) stable cycles at the target level.
module switch_bounce_gen
   import debounce_pkg::*;
#(
   parameter int          CNT_W = 8,
   parameter logic [15:0] SEED  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             level,
   input  logic [CNT_W-1:0] bounce_cycles,
   input  logic [CNT_W-1:0] settle_cycles,
   input  logic             abort,
   output logic             sw,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

   bounce_state_t     state_q, state_d;
   logic [CNT_W-1:0]  b_cnt_q, b_cnt_d;   // bounce cycles left, incl. current
   logic [CNT_W-1:0]  s_cnt_q, s_cnt_d;   // settle cycles left, incl. current
   logic              level_q, level_d;
   logic              sw_q, sw_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              lfsr_en_s;
   logic [LFSR_W-1:0] lfsr_s;

   // The LFSR moves once for every cycle spent in BOUNCE.
   assign lfsr_en_s = (state_d == BOUNCE);

   bounce_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (lfsr_en_s),
      .seed  (SEED),
      .out   (lfsr_s)
   );

   // Next-state and next-output logic; outputs describe the coming cycle.
   always_comb begin
      state_d = state_q;
      b_cnt_d = b_cnt_q;
      s_cnt_d = s_cnt_q;
      level_d = level_q;
      sw_d    = sw_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // abort in IDLE only suppresses a simultaneous request
            if (req && !abort) begin
               level_d = level;
               busy_d  = 1'b1;
               s_cnt_d = (settle_cycles == CNT_ZERO) ? CNT_ONE : settle_cycles;
               if (bounce_cycles == CNT_ZERO) begin
                  state_d = SETTLE;
                  b_cnt_d = CNT_ZERO;
                  sw_d    = level;
               end else begin
                  state_d = BOUNCE;
                  b_cnt_d = bounce_cycles;
                  sw_d    = (bounce_cycles == CNT_ONE) ? ~level : lfsr_s[0];
               end
            end else begin
               sw_d = sw_q;
            end
         end
         BOUNCE: begin
            if (abort) begin
               state_d = IDLE;
               b_cnt_d = CNT_ZERO;
               s_cnt_d = CNT_ZERO;
               sw_d    = level_q;
            end else if (b_cnt_q > CNT_ONE) begin
               busy_d  = 1'b1;
               b_cnt_d = b_cnt_q - CNT_ONE;
               // final bounce cycle always shows the opposite level
               sw_d    = (b_cnt_q == CNT_TWO) ? ~level_q : lfsr_s[0];
            end else begin
               busy_d  = 1'b1;
               state_d = SETTLE;
               b_cnt_d = CNT_ZERO;
               sw_d    = level_q;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
               s_cnt_d = CNT_ZERO;
               sw_d    = level_q;
            end else if (s_cnt_q > CNT_ONE) begin
               busy_d  = 1'b1;
               s_cnt_d = s_cnt_q - CNT_ONE;
               sw_d    = level_q;
            end else begin
               state_d = IDLE;
               s_cnt_d = CNT_ZERO;
               done_d  = 1'b1;
               sw_d    = level_q;
            end
         end
         default: begin
            state_d = IDLE;
            b_cnt_d = CNT_ZERO;
            s_cnt_d = CNT_ZERO;
            sw_d    = level_q;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         b_cnt_q <= CNT_ZERO;
         s_cnt_q <= CNT_ZERO;
         level_q <= 1'b0;
         sw_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         b_cnt_q <= b_cnt_d;
         s_cnt_q <= s_cnt_d;
         level_q <= level_d;
         sw_q    <= sw_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sw   = sw_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
